// File: rtl/bch_ecc_mem_reader.sv
// BCH ECC memory reader: fetches ECC words from helper-data memory,
// reassembles them and presents {data, ecc} to the decoder via valid/ready.
module bch_ecc_mem_reader #(
  parameter int C_D_BITS        = 16,
  parameter int C_E_BITS        = 20,
  parameter int C_MEM_ADDR_SIZE = 10,
  parameter int C_MEM_DATA_SIZE = 8,
  parameter int C_BASE_ADDR     = 0,
  parameter int C_RD_LAT        = 1
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_en,
  input  logic                         I_start,
  input  logic [C_D_BITS-1:0]          I_data,
  output logic [C_MEM_ADDR_SIZE-1:0]   O_mem_raddr,
  output logic                         O_mem_ren,
  input  logic [C_MEM_DATA_SIZE-1:0]   I_mem_rdata,
  output logic [C_D_BITS+C_E_BITS-1:0] O_cw_data,
  output logic                         O_cw_valid,
  input  logic                         I_cw_ready,
  output logic                         O_busy
);

  localparam int M  = C_MEM_DATA_SIZE;
  localparam int W  = (C_E_BITS + M - 1) / M;
  localparam int PW = W * M;
  localparam int CW = $clog2(W + 1);

  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] FULL = CW'(W);
  localparam logic [C_MEM_ADDR_SIZE-1:0] BASE =
    C_MEM_ADDR_SIZE'(C_BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       iss_q;
  logic [CW-1:0]       ret_q;
  logic [CW-1:0]       ret_d;
  logic [C_RD_LAT-1:0] vpipe_q;
  logic [C_D_BITS-1:0] data_q;
  logic [PW-1:0]       asm_q;
  logic                ret_vld;
  logic                accept;
  logic                last_iss;

  assign ret_vld  = vpipe_q[C_RD_LAT-1];
  assign ret_d    = ret_q + CW'(ret_vld);
  assign last_iss = (iss_q == LAST);
  assign accept   = (state_q == S_IDLE) && I_start;

  // ECC is left-aligned in the image; the pad LSBs are dropped here
  assign O_cw_data   = {data_q, asm_q[PW-1 -: C_E_BITS]};
  assign O_mem_raddr = BASE + C_MEM_ADDR_SIZE'(iss_q);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_start)         state_d = S_FETCH;
      S_FETCH: if (last_iss)        state_d = S_DRAIN;
      S_DRAIN: if (ret_d == FULL)   state_d = S_OUT;
      S_OUT:   if (I_cw_ready)      state_d = S_IDLE;
    endcase
    if (!I_en) state_d = S_IDLE;
  end

  always_comb begin
    O_mem_ren  = 1'b0;
    O_cw_valid = 1'b0;
    O_busy     = 1'b1;
    unique case (state_q)
      S_IDLE:  O_busy     = 1'b0;
      S_FETCH: O_mem_ren  = 1'b1;
      S_DRAIN: O_busy     = 1'b1;
      S_OUT:   O_cw_valid = 1'b1;
    endcase
  end

  // Clearing the valid pipe discards any reads still in flight
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      iss_q   <= '0;
      ret_q   <= '0;
      vpipe_q <= '0;
      data_q  <= '0;
      asm_q   <= '0;
    end else if (!I_en) begin
      iss_q   <= '0;
      ret_q   <= '0;
      vpipe_q <= '0;
      data_q  <= '0;
      asm_q   <= '0;
    end else begin
      vpipe_q[0] <= O_mem_ren;
      for (int i = 1; i < C_RD_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
      if (accept) begin
        data_q <= I_data;
        asm_q  <= '0;
        iss_q  <= '0;
        ret_q  <= '0;
      end else begin
        if (O_mem_ren) iss_q <= iss_q + CW'(1);
        if (ret_vld) begin
          asm_q <= (asm_q << M) | PW'(I_mem_rdata);
          ret_q <= ret_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_ecc_mem_reader.sv
// Bench for bch_ecc_mem_reader: two configurations, scoreboard for
// read addresses and codewords, directed timing/abort checks.
module tb_bch_ecc_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;

  logic        start0 = 1'b0;
  logic [15:0] data0 = '0;
  logic [9:0]  raddr0;
  logic        ren0;
  logic [7:0]  rdata0;
  logic [35:0] cw0;
  logic        valid0;
  logic        ready0 = 1'b1;
  logic        busy0;

  logic        start1 = 1'b0;
  logic [15:0] data1 = '0;
  logic [9:0]  raddr1;
  logic        ren1;
  logic [7:0]  rdata1;
  logic [31:0] cw1;
  logic        valid1;
  logic        ready1 = 1'b1;
  logic        busy1;

  logic [7:0]  mem0 [0:1023];
  logic [7:0]  mem1 [0:1023];
  logic [7:0]  r0;
  logic [7:0]  p1a, p1b, p1c;

  int errs = 0;
  int checks = 0;

  logic [35:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [9:0]  a0_q[$];
  logic [9:0]  a1_q[$];

  always #5 clk = ~clk;

  bch_ecc_mem_reader u0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_start(start0),
    .I_data(data0), .O_mem_raddr(raddr0), .O_mem_ren(ren0),
    .I_mem_rdata(rdata0), .O_cw_data(cw0), .O_cw_valid(valid0),
    .I_cw_ready(ready0), .O_busy(busy0)
  );

  bch_ecc_mem_reader #(
    .C_E_BITS(16), .C_BASE_ADDR('h3F0), .C_RD_LAT(3)
  ) u1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_start(start1),
    .I_data(data1), .O_mem_raddr(raddr1), .O_mem_ren(ren1),
    .I_mem_rdata(rdata1), .O_cw_data(cw1), .O_cw_valid(valid1),
    .I_cw_ready(ready1), .O_busy(busy1)
  );

  // memory models: 1-cycle and 3-cycle read pipelines
  always @(posedge clk) begin
    r0  <= mem0[raddr0];
    p1a <= mem1[raddr1];
    p1b <= p1a;
    p1c <= p1b;
  end
  assign rdata0 = r0;
  assign rdata1 = p1c;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: output with no expected entry", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && ren0) begin
      if (a0_q.size() == 0) miss("u0_raddr");
      else chk("u0_raddr", raddr0, a0_q.pop_front());
    end
    if (rst_n && ren1) begin
      if (a1_q.size() == 0) miss("u1_raddr");
      else chk("u1_raddr", raddr1, a1_q.pop_front());
    end
    if (valid0 && ready0) begin
      if (exp0_q.size() == 0) miss("u0_cw");
      else chk("u0_cw", cw0, exp0_q.pop_front());
    end
    if (valid1 && ready1) begin
      if (exp1_q.size() == 0) miss("u1_cw");
      else chk("u1_cw", cw1, exp1_q.pop_front());
    end
  end

  task automatic run0(input logic [15:0] d, input logic [35:0] cw);
    int n;
    exp0_q.push_back(cw);
    for (int k = 0; k < 3; k++) a0_q.push_back(10'(k));
    @(posedge clk); #1;
    data0 = d;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("u0_busy_c1", busy0, 1);
      if (valid0) begin
        n = k;
        break;
      end
    end
    chk("u0_valid_cycle", n, 5);
  endtask

  task automatic run1(input logic [15:0] d, input logic [31:0] cw);
    int n;
    exp1_q.push_back(cw);
    for (int k = 0; k < 2; k++) a1_q.push_back(10'h3F0 + 10'(k));
    @(posedge clk); #1;
    data1 = d;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("u1_busy_c1", busy1, 1);
      if (valid1) begin
        n = k;
        break;
      end
    end
    chk("u1_valid_cycle", n, 6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1, v2;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[0] = 8'hAB; mem0[1] = 8'hCD; mem0[2] = 8'hE0;
    mem1[10'h3F0] = 8'h5A; mem1[10'h3F1] = 8'hC3;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_raddr0", raddr0, 10'h000);
    chk("rst_raddr1", raddr1, 10'h3F0);
    chk("rst_ren0", ren0, 0);
    chk("rst_cw0", cw0, 0);
    chk("rst_valid0", valid0, 0);
    chk("rst_busy0", busy0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_busy0", busy0, 0);
    chk("rel_valid1", valid1, 0);

    // basic fetch, then nonzero pad
    run0(16'h1234, 36'h1234ABCDE);
    mem0[2] = 8'hEF;
    run0(16'h1234, 36'h1234ABCDE);

    // long latency, 16-bit ECC, high base address
    run1(16'hBEEF, 32'hBEEF5AC3);

    // backpressure: output held stable, stray start ignored
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h30;
    ready0 = 1'b0;
    run0(16'h0F0F, 36'h0F0F11223);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", valid0, 1);
      chk("hold_cw", cw0, 36'h0F0F11223);
      @(posedge clk); #1;
      if (i == 3) start0 = 1'b1;
      if (i == 4) start0 = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    ready0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_xfer_valid", valid0, 0);
    chk("post_xfer_busy", busy0, 0);

    // back-to-back with start held high
    mem0[0] = 8'hAB; mem0[1] = 8'hCD; mem0[2] = 8'hE0;
    exp0_q.push_back(36'hAAAAABCDE);
    exp0_q.push_back(36'h5555ABCDE);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) a0_q.push_back(10'(k));
    @(posedge clk); #1;
    data0 = 16'hAAAA;
    start0 = 1'b1;
    @(posedge clk); #1;
    data0 = 16'h5555;
    v1 = 0;
    v2 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (valid0) begin
        if (v1 == 0) v1 = k;
        else if (v2 == 0) v2 = k;
      end
      @(posedge clk); #1;
      if (k == 6) start0 = 1'b0;
    end
    chk("b2b_first_valid", v1, 5);
    chk("b2b_second_valid", v2, 11);

    // enable dropped mid-fetch, then a clean run
    a1_q.push_back(10'h3F0);
    a1_q.push_back(10'h3F1);
    @(posedge clk); #1;
    data1 = 16'h1111;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    chk("en_raddr1", raddr1, 10'h3F0);
    chk("en_ren1", ren1, 0);
    chk("en_cw1", cw1, 0);
    chk("en_valid1", valid1, 0);
    chk("en_busy1", busy1, 0);
    run1(16'h2222, 32'h22225AC3);

    // async reset pulse during drain, then a clean run
    a1_q.push_back(10'h3F0);
    a1_q.push_back(10'h3F1);
    @(posedge clk); #1;
    data1 = 16'h3333;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("drain_busy1", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ren1", ren1, 0);
    chk("arst_cw1", cw1, 0);
    chk("arst_valid1", valid1, 0);
    chk("arst_busy1", busy1, 0);
    chk("arst_raddr1", raddr1, 10'h3F0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_busy1_n", busy1, 0);
    run1(16'h4444, 32'h44445AC3);

    repeat (4) @(negedge clk);
    chk("q_exp0_empty", exp0_q.size(), 0);
    chk("q_exp1_empty", exp1_q.size(), 0);
    chk("q_a0_empty", a0_q.size(), 0);
    chk("q_a1_empty", a1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
